// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and helpers for the stopwatch core.
//   state_t     : top-level control states
//   bcd_t       : one BCD digit
//   SEC_MAX     : largest seconds value (binary and two-digit BCD form)
//   to_bcd2     : binary 0..99 to two-digit BCD (for parameter constants)
//   bcd2_inc    : two-digit BCD increment with wrap to 00 above max_v
//   bcd2_dec    : two-digit BCD decrement with wrap from 00 to max_v
// The inc/dec helpers return {wrapped, next_value}; the wrapped bit
// drives the carry/borrow into the next field.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUNNING = 2'd1,
    ADJUST  = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_MAX     = 59;
  localparam logic [7:0]  SEC_MAX_BCD = 8'h59;

  function automatic logic [7:0] to_bcd2(input int unsigned n);
    logic [7:0] r;
    r[7:4] = 4'((n / 10) % 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [8:0] bcd2_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [8:0] r;
    if (v == max_v)            r = {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)   r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                       r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [8:0] bcd2_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [8:0] r;
    if (v == 8'h00)            r = {1'b1, max_v};
    else if (v[3:0] == 4'd0)   r = {1'b0, v[7:4] - 4'd1, 4'd9};
    else                       r = {1'b0, v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// tick_gen: restartable modulo-DIV prescaler.
//   clk     : system clock
//   reset   : asynchronous active-low reset (counter to 0)
//   restart : synchronous return of the counter to 0
//   pulse   : high for one cycle when the counter sits at DIV-1,
//             i.e. DIV cycles after a restart (or after reset)
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic pulse
);

  localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  generate
    if (DIV == 0) begin : g_bad_div
      $error("tick_gen: DIV must be non-zero");
    end
  endgenerate

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (restart)      cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign pulse = (cnt == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: mm:ss up/down timekeeping core.
//   clk, reset            : system clock, asynchronous active-low reset
//   pause_pulse           : one-cycle start/stop toggle
//   clear_pulse           : one-cycle clear to 00:00
//   adj, sel              : adjust mode level; field select (0 min, 1 sec)
//   dir                   : 0 count up, 1 count down
//   min_tens..sec_units   : registered BCD digits
//   running/adjusting/done: one-hot view of RUNNING/ADJUST/DONE
//                           (all low means PAUSED)
//   blink_mask            : per-digit blank request, 1 = blank
// Control priority inside one cycle: adj > clear > pause > count tick.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned COUNT_HZ = 1,
  parameter int unsigned ADJ_HZ   = 2,
  parameter int unsigned BLINK_HZ = 1,
  parameter int unsigned MM_MAX   = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       adj,
  input  logic       sel,
  input  logic       dir,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       adjusting,
  output logic       done,
  output logic [3:0] blink_mask
);

  localparam int unsigned COUNT_DIV = (COUNT_HZ == 0) ? 0 : CLK_HZ / COUNT_HZ;
  localparam int unsigned ADJ_DIV   = (ADJ_HZ == 0)   ? 0 : CLK_HZ / ADJ_HZ;
  localparam int unsigned BLINK_DIV = (BLINK_HZ == 0) ? 0 : CLK_HZ / (2 * BLINK_HZ);
  localparam logic [7:0]  MM_MAX_BCD = to_bcd2(MM_MAX);

  generate
    if (MM_MAX < 1 || MM_MAX > 99) begin : g_bad_mm_max
      $error("stopwatch_core: MM_MAX must be in 1..99");
    end
  endgenerate

  state_t     state, state_n;
  logic [7:0] min_q, min_n;
  logic [7:0] sec_q, sec_n;
  logic       phase;
  logic       count_tick, adj_tick, blink_tick;
  logic       count_restart, adj_restart;
  logic [8:0] sec_step, min_step;
  logic       at_zero;

  // Prescalers restart on entry so the first tick lands a full period
  // after the start pulse / adjust entry.
  assign count_restart = (state_n == RUNNING) && (state != RUNNING);
  assign adj_restart   = (state_n == ADJUST)  && (state != ADJUST);

  tick_gen #(.DIV(COUNT_DIV)) u_count_tick (
    .clk(clk), .reset(reset), .restart(count_restart), .pulse(count_tick)
  );

  tick_gen #(.DIV(ADJ_DIV)) u_adj_tick (
    .clk(clk), .reset(reset), .restart(adj_restart), .pulse(adj_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk(clk), .reset(reset), .restart(1'b0), .pulse(blink_tick)
  );

  assign at_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PAUSED;
      min_q <= 8'h00;
      sec_q <= 8'h00;
      phase <= 1'b0;
    end else begin
      state <= state_n;
      min_q <= min_n;
      sec_q <= sec_n;
      if (blink_tick) phase <= ~phase;
    end
  end

  always_comb begin
    state_n  = state;
    min_n    = min_q;
    sec_n    = sec_q;
    sec_step = 9'd0;
    min_step = 9'd0;

    // Clear always zeroes the value; its effect on state depends on adj.
    if (clear_pulse) begin
      min_n = 8'h00;
      sec_n = 8'h00;
    end

    if (adj) begin
      state_n = ADJUST;
    end else begin
      case (state)
        ADJUST: state_n = PAUSED;
        PAUSED: begin
          // A down-count from 00:00 would finish instantly; refuse to start.
          if (!clear_pulse && pause_pulse && !(dir && at_zero))
            state_n = RUNNING;
        end
        RUNNING: begin
          if (clear_pulse || pause_pulse) begin
            state_n = PAUSED;
          end else if (count_tick) begin
            if (!dir) begin
              if (min_q == MM_MAX_BCD && sec_q == SEC_MAX_BCD) begin
                state_n = DONE;
              end else begin
                sec_step = bcd2_inc(sec_q, SEC_MAX_BCD);
                sec_n    = sec_step[7:0];
                if (sec_step[8]) begin
                  min_step = bcd2_inc(min_q, MM_MAX_BCD);
                  min_n    = min_step[7:0];
                end
              end
            end else begin
              // dir may flip while running at 00:00; treat that as done
              // rather than underflowing.
              if (at_zero) begin
                state_n = DONE;
              end else begin
                sec_step = bcd2_dec(sec_q, SEC_MAX_BCD);
                sec_n    = sec_step[7:0];
                if (sec_step[8]) begin
                  min_step = bcd2_dec(min_q, MM_MAX_BCD);
                  min_n    = min_step[7:0];
                end
                if (min_n == 8'h00 && sec_n == 8'h00) state_n = DONE;
              end
            end
          end
        end
        DONE: begin
          if (clear_pulse) state_n = PAUSED;
        end
        default: state_n = PAUSED;
      endcase
    end

    // Field adjustment: no carry between fields.
    if (state == ADJUST && adj && adj_tick && !clear_pulse) begin
      if (sel) begin
        sec_step = bcd2_inc(sec_q, SEC_MAX_BCD);
        sec_n    = sec_step[7:0];
      end else begin
        min_step = bcd2_inc(min_q, MM_MAX_BCD);
        min_n    = min_step[7:0];
      end
    end
  end

  always_comb begin
    blink_mask = 4'b0000;
    if (phase) begin
      if (state == ADJUST)    blink_mask = sel ? 4'b0011 : 4'b1100;
      else if (state == DONE) blink_mask = 4'b1111;
    end
  end

  assign min_tens  = min_q[7:4];
  assign min_units = min_q[3:0];
  assign sec_tens  = sec_q[7:4];
  assign sec_units = sec_q[3:0];
  assign running   = (state == RUNNING);
  assign adjusting = (state == ADJUST);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed bench for stopwatch_core with
// CLK_HZ=8, COUNT_HZ=1, ADJ_HZ=2, BLINK_HZ=1, MM_MAX=2, so a count tick
// every 8 cycles, an adjust step every 4 cycles and a blink toggle
// every 4 cycles. Inputs are driven and outputs sampled on negedge.
module tb_stopwatch_core;

  logic       clk;
  logic       reset;
  logic       pause_pulse, clear_pulse, adj, sel, dir;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       running, adjusting, done;
  logic [3:0] blink_mask;

  logic [15:0] digits;
  logic [2:0]  flags;
  assign digits = {min_tens, min_units, sec_tens, sec_units};
  assign flags  = {running, adjusting, done};

  int total  = 0;
  int passed = 0;

  stopwatch_core #(
    .CLK_HZ(8), .COUNT_HZ(1), .ADJ_HZ(2), .BLINK_HZ(1), .MM_MAX(2)
  ) dut (
    .clk(clk), .reset(reset),
    .pause_pulse(pause_pulse), .clear_pulse(clear_pulse),
    .adj(adj), .sel(sel), .dir(dir),
    .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units),
    .running(running), .adjusting(adjusting), .done(done),
    .blink_mask(blink_mask)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_pause();
    pause_pulse = 1'b1;
    step(1);
    pause_pulse = 1'b0;
  endtask

  task automatic do_clear();
    clear_pulse = 1'b1;
    step(1);
    clear_pulse = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0; pause_pulse = 1'b0; clear_pulse = 1'b0;
    adj = 1'b0; sel = 1'b0; dir = 1'b0;
    #3;
    total++; if (digits !== 16'h0000) $display("FAIL reset_digits: got %h want 0000", digits); else passed++;
    total++; if (flags !== 3'b000) $display("FAIL reset_flags: got %b want 000", flags); else passed++;
    total++; if (blink_mask !== 4'b0000) $display("FAIL reset_mask: got %b want 0000", blink_mask); else passed++;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_start();
    step(3);
    total++; if (digits !== 16'h0000 || flags !== 3'b000) $display("FAIL idle: digits %h flags %b want 0000/000", digits, flags); else passed++;
    do_pause();
    total++; if (flags !== 3'b100) $display("FAIL start_running: flags %b want 100", flags); else passed++;
    step(7);
    total++; if (digits !== 16'h0000) $display("FAIL start_before_tick: got %h want 0000", digits); else passed++;
    step(1);
    total++; if (digits !== 16'h0001) $display("FAIL start_tick1: got %h want 0001", digits); else passed++;
    total++; if (blink_mask !== 4'b0000) $display("FAIL run_mask: got %b want 0000", blink_mask); else passed++;
    step(8);
    total++; if (digits !== 16'h0002) $display("FAIL start_tick2: got %h want 0002", digits); else passed++;
  endtask

  task automatic test_run_to_done();
    logic [3:0] m [8];
    int ones;
    step(58 * 8);
    total++; if (digits !== 16'h0100) $display("FAIL carry_minute: got %h want 0100", digits); else passed++;
    step(119 * 8);
    total++; if (digits !== 16'h0259 || flags !== 3'b100) $display("FAIL at_max: digits %h flags %b want 0259/100", digits, flags); else passed++;
    step(8);
    total++; if (digits !== 16'h0259 || flags !== 3'b001) $display("FAIL max_done: digits %h flags %b want 0259/001", digits, flags); else passed++;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      m[i] = blink_mask;
      if (blink_mask == 4'b1111) ones++;
      total++; if (blink_mask !== 4'b0000 && blink_mask !== 4'b1111) $display("FAIL done_mask_value: got %b want 0000 or 1111", blink_mask); else passed++;
    end
    total++; if (ones !== 4) $display("FAIL done_mask_duty: got %0d blank cycles want 4", ones); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (m[i] === m[i+4]) $display("FAIL done_mask_toggle: cycle %0d got %b same as 4 later", i, m[i]); else passed++;
    end
    do_pause();
    step(8);
    total++; if (digits !== 16'h0259 || flags !== 3'b001) $display("FAIL done_hold: digits %h flags %b want 0259/001", digits, flags); else passed++;
  endtask

  task automatic test_adjust_and_down();
    int ones;
    do_clear();
    total++; if (digits !== 16'h0000 || flags !== 3'b000) $display("FAIL clear_done: digits %h flags %b want 0000/000", digits, flags); else passed++;
    adj = 1'b1; sel = 1'b0;
    step(1);
    total++; if (flags !== 3'b010) $display("FAIL adj_enter: flags %b want 010", flags); else passed++;
    ones = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (blink_mask == 4'b1100) ones++;
      total++; if (blink_mask !== 4'b0000 && blink_mask !== 4'b1100) $display("FAIL adj_min_mask: got %b want 0000 or 1100", blink_mask); else passed++;
      if (i == 3) begin
        total++; if (digits !== 16'h0000) $display("FAIL adj_min_early: got %h want 0000", digits); else passed++;
      end
      if (i == 4) begin
        total++; if (digits !== 16'h0100) $display("FAIL adj_min_1: got %h want 0100", digits); else passed++;
      end
    end
    total++; if (digits !== 16'h0200) $display("FAIL adj_min_2: got %h want 0200", digits); else passed++;
    total++; if (ones !== 4) $display("FAIL adj_mask_duty: got %0d blank cycles want 4", ones); else passed++;
    adj = 1'b0;
    step(1);
    total++; if (digits !== 16'h0200 || flags !== 3'b000) $display("FAIL adj_exit: digits %h flags %b want 0200/000", digits, flags); else passed++;
    dir = 1'b1;
    do_pause();
    total++; if (flags !== 3'b100) $display("FAIL down_start: flags %b want 100", flags); else passed++;
    step(8);
    total++; if (digits !== 16'h0159) $display("FAIL down_borrow: got %h want 0159", digits); else passed++;
    step(118 * 8);
    total++; if (digits !== 16'h0001 || flags !== 3'b100) $display("FAIL down_0001: digits %h flags %b want 0001/100", digits, flags); else passed++;
    step(8);
    total++; if (digits !== 16'h0000 || flags !== 3'b001) $display("FAIL down_done: digits %h flags %b want 0000/001", digits, flags); else passed++;
  endtask

  task automatic test_adjust_wrap();
    int ones;
    dir = 1'b0;
    adj = 1'b1; sel = 1'b1;
    step(1);
    total++; if (flags !== 3'b010) $display("FAIL adj_from_done: flags %b want 010", flags); else passed++;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (blink_mask == 4'b0011) ones++;
      total++; if (blink_mask !== 4'b0000 && blink_mask !== 4'b0011) $display("FAIL adj_sec_mask: got %b want 0000 or 0011", blink_mask); else passed++;
    end
    total++; if (ones !== 4) $display("FAIL adj_sec_duty: got %0d blank cycles want 4", ones); else passed++;
    step(59 * 4 - 8);
    total++; if (digits !== 16'h0059) $display("FAIL adj_sec_59: got %h want 0059", digits); else passed++;
    step(4);
    total++; if (digits !== 16'h0000) $display("FAIL adj_sec_wrap: got %h want 0000", digits); else passed++;
    sel = 1'b0;
    step(4);
    total++; if (digits !== 16'h0100) $display("FAIL adj_sel_min1: got %h want 0100", digits); else passed++;
    step(4);
    total++; if (digits !== 16'h0200) $display("FAIL adj_sel_min2: got %h want 0200", digits); else passed++;
    step(4);
    total++; if (digits !== 16'h0000) $display("FAIL adj_min_wrap: got %h want 0000", digits); else passed++;
    adj = 1'b0;
    step(1);
    total++; if (flags !== 3'b000) $display("FAIL adj_to_paused: flags %b want 000", flags); else passed++;
  endtask

  task automatic test_clear_and_reset();
    do_pause();
    step(56);
    total++; if (digits !== 16'h0007) $display("FAIL clr_pre: got %h want 0007", digits); else passed++;
    step(7);
    // this cycle carries the count tick
    do_clear();
    total++; if (digits !== 16'h0000 || flags !== 3'b000) $display("FAIL clr_vs_tick: digits %h flags %b want 0000/000", digits, flags); else passed++;
    step(8);
    total++; if (digits !== 16'h0000) $display("FAIL clr_stays: got %h want 0000", digits); else passed++;
    do_pause();
    step(9);
    total++; if (digits !== 16'h0001 || flags !== 3'b100) $display("FAIL pre_async: digits %h flags %b want 0001/100", digits, flags); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (digits !== 16'h0000 || flags !== 3'b000 || blink_mask !== 4'b0000) $display("FAIL async_reset: digits %h flags %b mask %b want 0000/000/0000", digits, flags, blink_mask); else passed++;
    step(1);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_pause_resume();
    dir = 1'b0;
    do_pause();
    step(24);
    total++; if (digits !== 16'h0003) $display("FAIL pr_0003: got %h want 0003", digits); else passed++;
    do_pause();
    total++; if (flags !== 3'b000) $display("FAIL pr_stop: flags %b want 000", flags); else passed++;
    for (int i = 0; i < 20; i++) begin
      step(1);
      total++; if (digits !== 16'h0003) $display("FAIL pr_frozen: cycle %0d got %h want 0003", i, digits); else passed++;
    end
    do_pause();
    step(7);
    total++; if (digits !== 16'h0003) $display("FAIL pr_resume_early: got %h want 0003", digits); else passed++;
    step(1);
    total++; if (digits !== 16'h0004) $display("FAIL pr_resume_tick: got %h want 0004", digits); else passed++;
    do_clear();
    dir = 1'b1;
    do_pause();
    total++; if (flags !== 3'b000) $display("FAIL down_zero_start: flags %b want 000", flags); else passed++;
    step(9);
    total++; if (digits !== 16'h0000 || flags !== 3'b000) $display("FAIL down_zero_hold: digits %h flags %b want 0000/000", digits, flags); else passed++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_run_to_done();
    test_adjust_and_down();
    test_adjust_wrap();
    test_clear_and_reset();
    test_pause_resume();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
